gemm_lane_ctrl: RTL

GEMM_LANE_CTRL -- requirements
Module: gemm_lane_ctrl

---
 rtl/gemm_lane_ctrl.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/gemm_lane_ctrl.sv
// gemm_lane_ctrl -- sequencer for a LANES-wide integer GEMM tile engine.
// Computes C(MxNcols) = A(MxK) * B(KxNcols), all row-major, reading one A word
// and LANES adjacent B words per k step from synchronous (1-cycle) BRAMs and
// writing C one word per cycle.
//
// Ports
//   clk, rstn            clock (rising edge), synchronous active-low reset
//   start, abort         launch request / cancel running job
//   M, K, Ncols          job dimensions, sampled on accepted start
//   mode, sat_en         operand precision (0=int8,1=int16,2=int32), result saturation
//   busy, done, err      job in progress / one-cycle completion / one-cycle reject
//   addr_A, data_A       A read port
//   addr_B, data_B       B read port, lane l on data_B[32l+:32]
//   addr_C, data_C, we_C C write port
//
// All outputs are registered; they are computed from the next state so that
// they line up with the state they belong to.
module gemm_lane_ctrl #(
   parameter int unsigned ADDR_W = 14,
   parameter int unsigned LANES  = 4,
   parameter int unsigned ACC_W  = 40
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                start,
   input  logic                abort,
   input  logic [15:0]         M,
   input  logic [15:0]         K,
   input  logic [15:0]         Ncols,
   input  logic [1:0]          mode,
   input  logic                sat_en,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [ADDR_W-1:0]   addr_A,
   input  logic [31:0]         data_A,
   output logic [ADDR_W-1:0]   addr_B,
   input  logic [32*LANES-1:0] data_B,
   output logic [ADDR_W-1:0]   addr_C,
   output logic [31:0]         data_C,
   output logic                we_C
);

   localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [2:0] {
      IDLE, ISSUE, CAPTURE, MAC, STORE, NEXT, DONE
   } state_e;

   state_e             state_q, state_d;
   logic [15:0]        m_q, m_d, kd_q, kd_d, n_q, n_d;
   logic [1:0]         mode_q, mode_d;
   logic               sat_q, sat_d;
   logic [15:0]        i_q, i_d, k_q, k_d, j0_q, j0_d;
   logic [LW-1:0]      l_q, l_d;
   logic [31:0]        a_q, a_d;
   logic [31:0]        b_q [LANES];
   logic [31:0]        b_d [LANES];
   logic [ACC_W-1:0]   acc_q [LANES];
   logic [ACC_W-1:0]   acc_d [LANES];
   logic               busy_q, busy_d, done_q, done_d, err_q, err_d, we_c_q, we_c_d;
   logic [ADDR_W-1:0]  addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_c_q, addr_c_d;
   logic [31:0]        data_c_q, data_c_d;

   // Sign-extend the active operand field to the accumulator width. With both
   // operands extended to ACC_W, the truncated product equals the signed product
   // modulo 2^ACC_W.
   function automatic logic [ACC_W-1:0] ext(input logic [31:0] v, input logic [1:0] m);
      logic signed [7:0]  s8;
      logic signed [15:0] s16;
      logic signed [31:0] s32;
      s8  = v[7:0];
      s16 = v[15:0];
      s32 = v;
      case (m)
         2'd0:    ext = ACC_W'(s8);
         2'd1:    ext = ACC_W'(s16);
         default: ext = ACC_W'(s32);
      endcase
   endfunction

   // In range when all bits from 31 upward agree with the sign.
   function automatic logic [31:0] clamp32(input logic [ACC_W-1:0] v, input logic en);
      logic [ACC_W-32:0] hi;
      hi = v[ACC_W-1:31];
      if (!en || hi == '0 || hi == '1) clamp32 = v[31:0];
      else if (v[ACC_W-1])             clamp32 = 32'h8000_0000;
      else                             clamp32 = 32'h7FFF_FFFF;
   endfunction

   always_comb begin
      state_d  = state_q;
      m_d      = m_q;
      kd_d     = kd_q;
      n_d      = n_q;
      mode_d   = mode_q;
      sat_d    = sat_q;
      i_d      = i_q;
      k_d      = k_q;
      j0_d     = j0_q;
      l_d      = l_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      err_d    = 1'b0;
      addr_a_d = addr_a_q;
      addr_b_d = addr_b_q;
      addr_c_d = addr_c_q;
      data_c_d = data_c_q;

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               if (M == '0 || K == '0 || Ncols == '0 || mode == 2'd3) begin
                  err_d = 1'b1;
               end else begin
                  m_d    = M;
                  kd_d   = K;
                  n_d    = Ncols;
                  mode_d = mode;
                  sat_d  = sat_en;
                  i_d    = '0;
                  k_d    = '0;
                  j0_d   = '0;
                  l_d    = '0;
                  for (int unsigned l = 0; l < LANES; l++) acc_d[l] = '0;
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: state_d = CAPTURE;
         CAPTURE: begin
            a_d = data_A;
            for (int unsigned l = 0; l < LANES; l++) b_d[l] = data_B[32*l +: 32];
            state_d = MAC;
         end
         MAC: begin
            for (int unsigned l = 0; l < LANES; l++)
               acc_d[l] = acc_q[l] + ext(a_q, mode_q) * ext(b_q[l], mode_q);
            if (32'(k_q) + 32'd1 < 32'(kd_q)) begin
               k_d     = k_q + 16'd1;
               state_d = ISSUE;
            end else begin
               l_d     = '0;
               state_d = STORE;
            end
         end
         STORE: begin
            // Only lanes that map onto a real column are written.
            if (32'(l_q) + 32'd1 < LANES && 32'(j0_q) + 32'(l_q) + 32'd1 < 32'(n_q))
               l_d = l_q + LW'(1);
            else
               state_d = NEXT;
         end
         NEXT: begin
            for (int unsigned l = 0; l < LANES; l++) acc_d[l] = '0;
            k_d = '0;
            l_d = '0;
            if (32'(j0_q) + LANES >= 32'(n_q)) begin
               j0_d = '0;
               if (32'(i_q) + 32'd1 >= 32'(m_q)) begin
                  state_d = DONE;
               end else begin
                  i_d     = i_q + 16'd1;
                  state_d = ISSUE;
               end
            end else begin
               j0_d    = j0_q + 16'(LANES);
               state_d = ISSUE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (abort && state_q != IDLE) state_d = IDLE;

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
      we_c_d = (state_d == STORE);
      if (state_d == ISSUE) begin
         addr_a_d = ADDR_W'(32'(i_d) * 32'(kd_d) + 32'(k_d));
         addr_b_d = ADDR_W'(32'(k_d) * 32'(n_d) + 32'(j0_d));
      end
      if (state_d == STORE) begin
         addr_c_d = ADDR_W'(32'(i_d) * 32'(n_d) + 32'(j0_d) + 32'(l_d));
         data_c_d = clamp32(acc_d[l_d], sat_d);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= IDLE;
         m_q      <= '0;
         kd_q     <= '0;
         n_q      <= '0;
         mode_q   <= '0;
         sat_q    <= 1'b0;
         i_q      <= '0;
         k_q      <= '0;
         j0_q     <= '0;
         l_q      <= '0;
         a_q      <= '0;
         for (int unsigned l = 0; l < LANES; l++) begin
            b_q[l]   <= '0;
            acc_q[l] <= '0;
         end
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         we_c_q   <= 1'b0;
         addr_a_q <= '0;
         addr_b_q <= '0;
         addr_c_q <= '0;
         data_c_q <= '0;
      end else begin
         state_q  <= state_d;
         m_q      <= m_d;
         kd_q     <= kd_d;
         n_q      <= n_d;
         mode_q   <= mode_d;
         sat_q    <= sat_d;
         i_q      <= i_d;
         k_q      <= k_d;
         j0_q     <= j0_d;
         l_q      <= l_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         we_c_q   <= we_c_d;
         addr_a_q <= addr_a_d;
         addr_b_q <= addr_b_d;
         addr_c_q <= addr_c_d;
         data_c_q <= data_c_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;
   assign we_C   = we_c_q;
   assign addr_A = addr_a_q;
   assign addr_B = addr_b_q;
   assign addr_C = addr_c_q;
   assign data_C = data_c_q;

endmodule
